la_trg_seq: RTL

//  Multi-stage trigger sequencer for the logic analyzer; next generation of the single-stage la_trigger.

---
 rtl/la_trg_seq_pkg.sv | 14 +
 rtl/la_trg_seq_if.sv | 15 +
 rtl/la_trg_seq_cmp.sv | 26 ++
 rtl/la_trg_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/la_trg_seq_pkg.sv
// Shared types for the la_trg_seq trigger sequencer.
//   la_seq_st_t : sequencer state (IDLE / ARMED / DONE)
//   LA_SN_MAX   : largest supported stage count
package la_trg_seq_pkg;

    localparam int LA_SN_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } la_seq_st_t;

endpackage

// File: rtl/la_trg_seq_if.sv
// Single-lane AXI4-stream bundle.
//   s : source (master) side, drives TVALID/TDATA/TKEEP/TLAST, samples TREADY
//   d : destination (slave) side, samples payload, drives TREADY
interface axi4_stream_if #(
    parameter int DW = 16
) ();
    logic          TVALID;
    logic          TREADY;
    logic [DW-1:0] TDATA;
    logic          TKEEP;
    logic          TLAST;

    modport s (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
    modport d (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface

// File: rtl/la_trg_seq_cmp.sv
// Combinational stage matcher for one sequencer stage.
//   msk_i/val_i : masked equality compare of d_i against val_i
//   pos_i/neg_i : rising/falling edge selects against prev_i
//   pv_i        : prev_i holds a real earlier beat
//   hit_o       : compare and edge conditions both satisfied
module la_trg_seq_cmp #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] msk_i,
    input  logic [DW-1:0] val_i,
    input  logic [DW-1:0] pos_i,
    input  logic [DW-1:0] neg_i,
    input  logic [DW-1:0] d_i,
    input  logic [DW-1:0] prev_i,
    input  logic          pv_i,
    output logic          hit_o
);
    logic cmp, edg_sel, edg;

    assign cmp     = ((d_i ^ val_i) & msk_i) == '0;
    assign edg_sel = |(pos_i | neg_i);
    // No edge history right after arming, so edge terms cannot fire yet.
    assign edg     = pv_i & ((|(pos_i & ~prev_i & d_i)) | (|(neg_i & prev_i & ~d_i)));
    // A stage with no edge selects matches on compare alone.
    assign hit_o   = cmp & (~edg_sel | edg);
endmodule

// File: rtl/la_trg_seq.sv
// Multi-stage trigger sequencer for the logic analyzer.
// Watches an AXI4-stream through a one-beat register slice and walks up to SN
// stages (mask/value match, edge match, occurrence count); pulses trg_out when
// the last active stage completes.
//   clk, rst          : clock, async active-high reset
//   sti / sto         : monitored input stream / registered copy
//   ctl_rst, ctl_arm  : synchronous clear / start at stage 0
//   cfg_*             : continuous mode, last stage, per-stage match config
//   sts_arm/stg/cnt   : armed flag, current stage, hits in current stage
//   trg_out           : one-cycle trigger, aligned with the triggering beat on sto
module la_trg_seq
    import la_trg_seq_pkg::*;
#(
    parameter  int DW = 16,
    parameter  int SN = 4,
    parameter  int CW = 16,
    localparam int SW = (SN > 1) ? $clog2(SN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4_stream_if.d              sti,
    axi4_stream_if.s              sto,
    input  logic                  ctl_rst,
    input  logic                  ctl_arm,
    input  logic                  cfg_con,
    input  logic [SW-1:0]         cfg_lst,
    input  logic [SN-1:0][DW-1:0] cfg_msk,
    input  logic [SN-1:0][DW-1:0] cfg_val,
    input  logic [SN-1:0][DW-1:0] cfg_pos,
    input  logic [SN-1:0][DW-1:0] cfg_neg,
    input  logic [SN-1:0][CW-1:0] cfg_cnt,
    output logic                  sts_arm,
    output logic [SW-1:0]         sts_stg,
    output logic [CW-1:0]         sts_cnt,
    output logic                  trg_out
);
    typedef struct packed {
        logic [DW-1:0] msk;
        logic [DW-1:0] val;
        logic [DW-1:0] pos;
        logic [DW-1:0] neg;
        logic [CW-1:0] cnt;
    } la_stg_cfg_t;

    la_seq_st_t    st_q, st_d;
    logic [SW-1:0] stg_q, stg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trg_q, trg_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          pv_q, pv_d;

    logic          sto_vld_q;
    logic [DW-1:0] sto_dat_q;
    logic          sto_keep_q, sto_last_q;

    logic          rdy, beat, hit, done;
    la_stg_cfg_t   cur;
    logic [SW-1:0] lst;
    logic [CW:0]   cnt_inc;
    logic [CW-1:0] tgt;

    // ---- register slice ----
    assign rdy        = ~sto_vld_q | sto.TREADY;
    assign sti.TREADY = rdy;
    assign beat       = sti.TVALID & rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sto_vld_q  <= 1'b0;
            sto_dat_q  <= '0;
            sto_keep_q <= 1'b0;
            sto_last_q <= 1'b0;
        end else if (ctl_rst) begin
            sto_vld_q  <= 1'b0;
        end else if (beat) begin
            sto_vld_q  <= 1'b1;
            sto_dat_q  <= sti.TDATA;
            sto_keep_q <= sti.TKEEP;
            sto_last_q <= sti.TLAST;
        end else if (sto.TREADY) begin
            sto_vld_q  <= 1'b0;
        end
    end

    assign sto.TVALID = sto_vld_q;
    assign sto.TDATA  = sto_dat_q;
    assign sto.TKEEP  = sto_keep_q;
    assign sto.TLAST  = sto_last_q;

    // ---- current-stage config and matcher ----
    always_comb begin
        cur = '{msk: cfg_msk[stg_q], val: cfg_val[stg_q], pos: cfg_pos[stg_q],
                neg: cfg_neg[stg_q], cnt: cfg_cnt[stg_q]};
    end

    la_trg_seq_cmp #(.DW(DW)) u_cmp (
        .msk_i  (cur.msk),
        .val_i  (cur.val),
        .pos_i  (cur.pos),
        .neg_i  (cur.neg),
        .d_i    (sti.TDATA),
        .prev_i (prev_q),
        .pv_i   (pv_q),
        .hit_o  (hit)
    );

    assign lst     = (int'(cfg_lst) > SN - 1) ? SW'(SN - 1) : cfg_lst;
    // One extra bit so a hit at an all-ones count cannot wrap the compare.
    assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
    assign tgt     = (cur.cnt == '0) ? CW'(1) : cur.cnt;
    assign done    = cnt_inc >= {1'b0, tgt};

    // ---- sequencer FSM ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            stg_q  <= '0;
            cnt_q  <= '0;
            trg_q  <= 1'b0;
            prev_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            stg_q  <= stg_d;
            cnt_q  <= cnt_d;
            trg_q  <= trg_d;
            prev_q <= prev_d;
            pv_q   <= pv_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        stg_d  = stg_q;
        cnt_d  = cnt_q;
        trg_d  = 1'b0;
        prev_d = prev_q;
        pv_d   = pv_q;
        if (beat) begin
            prev_d = sti.TDATA;
            pv_d   = 1'b1;
        end
        if (ctl_rst) begin
            st_d  = IDLE;
            stg_d = '0;
            cnt_d = '0;
            pv_d  = 1'b0;
        end else if (ctl_arm) begin
            st_d  = ARMED;
            stg_d = '0;
            cnt_d = '0;
            pv_d  = 1'b0;
        end else if (st_q == ARMED && beat && hit) begin
            if (done) begin
                cnt_d = '0;
                // >= keeps a lowered cfg_lst from letting the stage index run off.
                if (stg_q >= lst) begin
                    trg_d = 1'b1;
                    stg_d = '0;
                    st_d  = cfg_con ? ARMED : DONE;
                end else begin
                    stg_d = stg_q + SW'(1);
                end
            end else begin
                cnt_d = cnt_inc[CW-1:0];
            end
        end
    end

    assign sts_arm = (st_q == ARMED);
    assign sts_stg = stg_q;
    assign sts_cnt = cnt_q;
    assign trg_out = trg_q;
endmodule
